// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared widths, digit limits, digit indices and FSM encoding for the stopwatch
package stopwatch_pkg;
  localparam int DIGIT_W = 4;
  localparam int NUM_DIGITS = 8;
  localparam logic [DIGIT_W-1:0] MAX_DEC = 4'd9;
  localparam logic [DIGIT_W-1:0] MAX_SEX = 4'd5;
  localparam int IDX_C0 = 0;
  localparam int IDX_C1 = 1;
  localparam int IDX_S0 = 2;
  localparam int IDX_S1 = 3;
  localparam int IDX_M0 = 4;
  localparam int IDX_M1 = 5;
  localparam int IDX_H0 = 6;
  localparam int IDX_H1 = 7;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVF} state_t;
  function automatic logic [DIGIT_W-1:0] digit_max(input int idx);
    return (idx == IDX_S1 || idx == IDX_M1) ? MAX_SEX : MAX_DEC;
  endfunction
endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: one BCD digit counting 0..MAX; o_carry flags terminal value so the top can ripple enables
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_inc,
  output logic [DIGIT_W-1:0] o_val,
  output logic               o_carry
);
  logic [DIGIT_W-1:0] r_val;
  assign o_val = r_val;
  // Values above MAX are treated as terminal so they wrap to 0 on the next advance
  assign o_carry = r_val >= MAX;
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_val <= '0;
    else if (i_inc) r_val <= o_carry ? '0 : r_val + 1'b1;
  end
endmodule

// File: rtl/stopwatch_time_counter.sv
// stopwatch_time_counter: centisecond prescaler + HH:MM:SS.cc BCD counter with run/pause/clear and saturation
// Optional lap freeze of o_digits is built when STOPWATCH_LAP_EN is defined.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start_stop,
  input  logic        i_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic        i_lap,
`endif
  output logic [31:0] o_digits,
  output logic        o_running,
  output logic        o_tick,
  output logic        o_overflow
);
  localparam int CS_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W = $clog2(CS_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CS_DIV - 1);
  state_t r_state, w_state_nx;
  logic [PRE_W-1:0] r_pre;
  logic r_tick, r_ovf;
  logic [NUM_DIGITS-1:0] w_inc, w_carry;
  logic [NUM_DIGITS*DIGIT_W-1:0] w_live;
  logic w_wrap, w_at_max, w_adv;
  assign w_wrap = (r_state == RUN) && (r_pre == PRE_LAST);
  assign w_at_max = &w_carry;
  assign w_adv = w_wrap && !w_at_max;
  always_comb begin
    w_inc[0] = w_adv;
    for (int k = 1; k < NUM_DIGITS; k++) w_inc[k] = w_inc[k-1] && w_carry[k-1];
  end
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_d
    bcd_digit_counter #(.MAX(digit_max(i))) u_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (i_clear),
      .i_inc   (w_inc[i]),
      .o_val   (w_live[i*DIGIT_W +: DIGIT_W]),
      .o_carry (w_carry[i])
    );
  end
  // Clear dominates; a saturating tick beats a simultaneous start_stop
  always_comb begin
    w_state_nx = r_state;
    if (i_clear) w_state_nx = i_start_stop ? RUN : IDLE;
    else if (w_wrap && w_at_max) w_state_nx = OVF;
    else if (i_start_stop && r_state != OVF) w_state_nx = (r_state == RUN) ? PAUSE : RUN;
  end
  always_ff @(posedge i_clk) r_state <= i_rst ? IDLE : w_state_nx;
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_pre <= '0;
      r_tick <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_pre <= w_wrap ? '0 : (r_state == RUN) ? r_pre + 1'b1 : r_pre;
      r_tick <= w_wrap;
      if (w_wrap && w_at_max) r_ovf <= 1'b1;
    end
  end
  assign o_running = r_state == RUN;
  assign o_tick = r_tick;
  assign o_overflow = r_ovf;
`ifdef STOPWATCH_LAP_EN
  logic r_frozen;
  logic [31:0] r_snap;
  logic w_lap;
  assign w_lap = i_lap && (r_state == RUN || r_state == PAUSE);
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_frozen <= 1'b0;
      r_snap <= '0;
    end else if (w_lap) begin
      r_frozen <= !r_frozen;
      if (!r_frozen) r_snap <= w_live;
    end
  end
  assign o_digits = r_frozen ? r_snap : w_live;
`else
  assign o_digits = w_live;
`endif
endmodule

// File: tb/tb_stopwatch_time_counter.sv
// tb_stopwatch_time_counter: scenario tasks plus random traffic against a centisecond-integer reference model
module tb_stopwatch_time_counter;
  localparam int CLK_HZ = 1000;
  localparam int TICK_HZ = 100;
  localparam int CS_DIV = CLK_HZ / TICK_HZ;
  localparam int MAX_CS = 99*360000 + 59*6000 + 59*100 + 99;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1, ss = 1'b0, clr = 1'b0, lap = 1'b0;
  logic [31:0] o_digits;
  logic o_running, o_tick, o_overflow;
  logic [34:0] obs;
  logic [31:0] poke_val;
  int n_pass = 0, n_tot = 0;
  int m_cs = 0, m_phase = 0, m_snap = 0;
  bit m_run = 0, m_ovf = 0, m_armed = 0, m_frz = 0, m_tick = 0;

  always #5 clk = ~clk;
  assign obs = {o_digits, o_running, o_tick, o_overflow};

  stopwatch_time_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start_stop (ss),
    .i_clear      (clr),
`ifdef STOPWATCH_LAP_EN
    .i_lap        (lap),
`endif
    .o_digits     (o_digits),
    .o_running    (o_running),
    .o_tick       (o_tick),
    .o_overflow   (o_overflow)
  );

  function automatic logic [31:0] bcd(input int cs);
    int h, m, s, c;
    h = cs / 360000;
    m = (cs / 6000) % 60;
    s = (cs / 100) % 60;
    c = cs % 100;
    return {4'(h/10), 4'(h%10), 4'(m/10), 4'(m%10), 4'(s/10), 4'(s%10), 4'(c/10), 4'(c%10)};
  endfunction

  function automatic logic [34:0] exp_vec();
    return {m_frz ? bcd(m_snap) : bcd(m_cs), m_run, m_tick, m_ovf};
  endfunction

  // Model: elapsed time is a plain centisecond integer; one call advances one clock
  task automatic model(input bit r, input bit s, input bit c, input bit l);
    if (r) begin
      m_cs = 0; m_phase = 0; m_run = 0; m_ovf = 0; m_armed = 0; m_frz = 0; m_snap = 0; m_tick = 0;
    end else if (c) begin
      m_cs = 0; m_phase = 0; m_ovf = 0; m_run = s; m_armed = s; m_frz = 0; m_tick = 0;
    end else begin
      m_tick = m_run && m_phase == CS_DIV - 1;
      if (LAP_EN && l && m_armed && !m_ovf) begin
        if (!m_frz) m_snap = m_cs;
        m_frz = !m_frz;
      end
      if (m_run) m_phase = m_tick ? 0 : m_phase + 1;
      if (m_tick) begin
        if (m_cs == MAX_CS) begin m_ovf = 1; m_run = 0; end
        else m_cs++;
      end
      if (s && !m_ovf) begin m_run = !m_run; m_armed = 1; end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit c, input bit l);
    @(negedge clk);
    rst = r; ss = s; clr = c; lap = l;
    model(r, s, c, l);
    @(posedge clk);
    #1;
    rst = 0; ss = 0; clr = 0; lap = 0;
  endtask

  // Loads the live count directly so far-away times are reachable; DUT must be paused
  task automatic poke(input int cs);
    @(negedge clk);
    poke_val = bcd(cs);
    force dut.g_d[0].u_cnt.r_val = poke_val[3:0];
    force dut.g_d[1].u_cnt.r_val = poke_val[7:4];
    force dut.g_d[2].u_cnt.r_val = poke_val[11:8];
    force dut.g_d[3].u_cnt.r_val = poke_val[15:12];
    force dut.g_d[4].u_cnt.r_val = poke_val[19:16];
    force dut.g_d[5].u_cnt.r_val = poke_val[23:20];
    force dut.g_d[6].u_cnt.r_val = poke_val[27:24];
    force dut.g_d[7].u_cnt.r_val = poke_val[31:28];
    #1;
    release dut.g_d[0].u_cnt.r_val;
    release dut.g_d[1].u_cnt.r_val;
    release dut.g_d[2].u_cnt.r_val;
    release dut.g_d[3].u_cnt.r_val;
    release dut.g_d[4].u_cnt.r_val;
    release dut.g_d[5].u_cnt.r_val;
    release dut.g_d[6].u_cnt.r_val;
    release dut.g_d[7].u_cnt.r_val;
    m_cs = cs;
    model(0, 0, 0, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    n_tot++;
    if (obs !== 35'h0) $display("FAIL reset_state: got %h want %h", obs, 35'h0);
    else n_pass++;
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0, 0);
      n_tot++;
      if (obs !== exp_vec()) $display("FAIL idle_cycle%0d: got %h want %h", i, obs, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_run_1s();
    int ticks = 0, first = -1;
    step(0, 1, 0, 0);
    for (int i = 1; i <= 1000; i++) begin
      step(0, 0, 0, 0);
      if (o_tick) begin
        ticks++;
        if (first < 0) first = i;
      end
      n_tot++;
      if (obs !== exp_vec()) $display("FAIL run_cycle%0d: got %h want %h", i, obs, exp_vec());
      else n_pass++;
    end
    n_tot++;
    if (first !== 10) $display("FAIL first_tick_latency: got %0d want 10", first);
    else n_pass++;
    n_tot++;
    if (ticks !== 100) $display("FAIL tick_count: got %0d want 100", ticks);
    else n_pass++;
    n_tot++;
    if (o_digits !== 32'h0000_0100) $display("FAIL one_second: got %h want 00000100", o_digits);
    else n_pass++;
  endtask

  task automatic test_rollover();
    int from [2] = '{5999, 359999};
    logic [31:0] want [2] = '{32'h0001_0000, 32'h0100_0000};
    step(0, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      poke(from[k]);
      step(0, 1, 0, 0);
      for (int i = 0; i < 12 && !o_tick; i++) step(0, 0, 0, 0);
      n_tot++;
      if (o_digits !== want[k]) $display("FAIL rollover%0d: got %h want %h", k, o_digits, want[k]);
      else n_pass++;
      n_tot++;
      if (obs !== exp_vec()) $display("FAIL rollover_model%0d: got %h want %h", k, obs, exp_vec());
      else n_pass++;
      step(0, 1, 0, 0);
    end
  endtask

  task automatic test_pause();
    logic [31:0] held;
    int n = 0;
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 40 && (m_phase != 4 || m_cs < 2); i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    held = o_digits;
    for (int i = 0; i < 50; i++) begin
      step(0, 0, 0, 0);
      n_tot++;
      if (obs !== exp_vec()) $display("FAIL paused_cycle%0d: got %h want %h", i, obs, exp_vec());
      else n_pass++;
    end
    n_tot++;
    if (o_digits !== held || o_running !== 1'b0) $display("FAIL paused_hold: got %h want %h", o_digits, held);
    else n_pass++;
    step(0, 1, 0, 0);
    do begin
      step(0, 0, 0, 0);
      n++;
    end while (!o_tick && n < 20);
    n_tot++;
    if (n !== 5) $display("FAIL resume_phase: got %0d want 5", n);
    else n_pass++;
  endtask

  task automatic test_overflow();
    step(0, 1, 0, 0);
    poke(MAX_CS);
    step(0, 1, 0, 0);
    for (int i = 0; i < 12 && !o_tick; i++) step(0, 0, 0, 0);
    n_tot++;
    if (obs !== {32'h9959_5999, 1'b0, 1'b1, 1'b1}) $display("FAIL saturate: got %h want %h", obs, {32'h9959_5999, 3'b011});
    else n_pass++;
    step(0, 1, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0);
    n_tot++;
    if (obs !== {32'h9959_5999, 1'b0, 1'b0, 1'b1}) $display("FAIL ovf_ignores_start: got %h want %h", obs, {32'h9959_5999, 3'b001});
    else n_pass++;
    step(0, 0, 1, 0);
    n_tot++;
    if (obs !== 35'h0) $display("FAIL ovf_clear: got %h want %h", obs, 35'h0);
    else n_pass++;
    step(0, 1, 0, 0);
    n_tot++;
    if (obs !== exp_vec() || o_running !== 1'b1) $display("FAIL restart_after_ovf: got %h want %h", obs, exp_vec());
    else n_pass++;
  endtask

  task automatic test_clear_tick();
    for (int i = 0; i < 35; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 20 && m_phase != CS_DIV - 1; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    n_tot++;
    if (obs !== 35'h0) $display("FAIL clear_on_tick: got %h want %h", obs, 35'h0);
    else n_pass++;
    step(0, 1, 0, 0);
    for (int i = 0; i < 25; i++) step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    n_tot++;
    if (obs !== {32'h0, 1'b1, 1'b0, 1'b0}) $display("FAIL clear_plus_start: got %h want %h", obs, {32'h0, 3'b100});
    else n_pass++;
  endtask

  task automatic test_lap();
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 3000 && m_cs != 250; i++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    n_tot++;
    if (o_digits !== 32'h0000_0250) $display("FAIL lap_freeze: got %h want 00000250", o_digits);
    else n_pass++;
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0, 0);
      n_tot++;
      if (obs !== exp_vec()) $display("FAIL lap_cycle%0d: got %h want %h", i, obs, exp_vec());
      else n_pass++;
    end
    n_tot++;
    if (o_digits !== 32'h0000_0250) $display("FAIL lap_hold: got %h want 00000250", o_digits);
    else n_pass++;
    step(0, 0, 0, 1);
    n_tot++;
    if (o_digits !== 32'h0000_0260) $display("FAIL lap_release: got %h want 00000260", o_digits);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(399) == 0, $urandom_range(19) == 0, $urandom_range(199) == 0, $urandom_range(29) == 0);
      n_tot++;
      if (obs !== exp_vec()) $display("FAIL random_cycle%0d: got %h want %h", i, obs, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run_1s();
    test_rollover();
    test_pause();
    test_overflow();
    test_clear_tick();
    if (LAP_EN) test_lap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
